axi_mem_responder: RTL and testbench
====================================

# axi_mem_responder

AXI4 slave responder that terminates a 64-bit AXI master port, such as the Rocket `Top` `io_mem_axi` port, with an on-chip BRAM. It stands in for the PS high-performance DDR slave when testing without the processing system, or when a small tightly-coupled memory is wanted. Read and write channels are served by independent state machines over a dual-port memory.

## Interface
- `MEM_WORDS_LOG2`, default 12: memory depth is 2^N 64-bit words (32 KiB by default).
- `BASE_HI`, default 4'h8: required value of `addr[31:28]`; other addresses decode-error.
- `clock` input, 1 bit: single clock for all logic.
- `reset_n` input, 1 bit: reset is asynchronous and active-low.
- `s_axi_awvalid` input, 1 bit / `s_axi_awready` output, 1 bit: write-address handshake.
- `s_axi_awaddr` input 32, `s_axi_awid` input 6, `s_axi_awlen` input 8, `s_axi_awsize` input 3, `s_axi_awburst` input 2: write-address payload.
- `s_axi_wvalid` input 1 / `s_axi_wready` output 1; `s_axi_wdata` input 64, `s_axi_wstrb` input 8, `s_axi_wlast` input 1: write data.
- `s_axi_bvalid` output 1 / `s_axi_bready` input 1; `s_axi_bid` output 6, `s_axi_bresp` output 2: write response.
- `s_axi_arvalid` input 1 / `s_axi_arready` output 1; `s_axi_araddr` input 32, `s_axi_arid` input 6, `s_axi_arlen` input 8, `s_axi_arsize` input 3, `s_axi_arburst` input 2: read-address channel.
- `s_axi_rvalid` output 1 / `s_axi_rready` input 1; `s_axi_rdata` output 64, `s_axi_rid` output 6, `s_axi_rresp` output 2, `s_axi_rlast` output 1: read data.
- Inputs not listed here (lock, cache, prot, qos, region) are absent and are ignored by the master side.

## Operation
- **Word index:** `addr[MEM_WORDS_LOG2+2:3]`.
- **In range:** `addr[31:28]==BASE_HI` and `addr[27:MEM_WORDS_LOG2+3]==0`.
- **Burst support:**
  - FIXED (00) and INCR (01) are supported.
  - INCR advances the address by `1<<size` per beat; sizes 0..3 are legal.
  - WRAP (10) and reserved (11) bursts complete the full beat count with SLVERR (10), perform no memory write, and return rdata 0.
  - A size greater than 3 is treated the same as WRAP.
- **Write FSM:**
  - W_IDLE: awready=1. An AW handshake latches id, addr, len, size, burst, clears the beat counter and the error flags, and moves to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the bytes enabled by wstrb when the beat is in range, otherwise it sets the DECERR flag. After beat len+1 the FSM moves to W_RESP.
  - If wlast disagrees with the beat count, the SLVERR flag is set. The burst length is always taken from awlen.
  - W_RESP: bvalid=1 with the latched bid. bresp priority is SLVERR, then DECERR, then OKAY. A B handshake returns to W_IDLE.
- **Read FSM:**
  - R_IDLE: arready=1. An AR handshake latches the request, issues a memory read of the first word and moves to R_FILL.
  - R_FILL: lasts one cycle, then moves to R_DATA.
  - R_DATA: rvalid=1. rlast=1 on beat len+1. rresp follows the write-side rules, evaluated per beat. An out-of-range beat returns rdata 0.
  - On an R handshake the next word is read in the same cycle, so beats are back-to-back while rready=1. A handshake on the last beat returns to R_IDLE.
- **Channel independence:** read and write proceed fully in parallel. There is no ordering between the two channels.
- **Same-word collision:** a same-cycle read and write of one word is read-first, so the read returns the old data.
- **Outstanding transactions:** one per channel. The AW and AR channels are not accepted again until the current burst's response completes.

## Timing
- **Reset values:** while reset_n=0, every output is 0, including awready, arready, wready, bvalid, rvalid, rlast, all ids, resps and rdata.
- **Ready after reset:** awready and arready rise at the first clock edge after reset_n deasserts.
- **Reset mid-burst:** the burst is aborted and no response is issued. Memory contents are retained because the BRAM is not reset.
- **Write latency:** bvalid asserts the cycle after the last W handshake. The next awready is the cycle after the B handshake.
- **Read latency:**
  - For an AR handshake at edge N, the first rvalid is at N+2.
  - With rready held high, a burst of L+1 beats completes at N+2+L.
  - arready returns the cycle after the last R handshake.
- **Backpressure stability:** while rvalid=1 and rready=0, rdata, rresp, rlast and rid hold stable, even if a concurrent write hits that word. bid and bresp hold stable while bvalid=1 and bready=0.
- **Wrap-around:** an INCR burst that runs past the top of memory keeps incrementing the 32-bit address. Beats beyond the range get DECERR; the index does not wrap.
- **Beat counter:** 9 bits, so len=255 gives 256 beats.

## Test plan
- **Single write then read:** write 0x8000_0040, len=0, size=3, data 0x0123456789ABCDEF, strb FF → bresp 00. Read of the same address → rdata matches, rlast=1, rvalid at AR edge+2.
- **INCR burst with stalls:** write len=7 of data i at 0x8000_0100, then read it back with rready toggling every cycle → 8 beats with data 0..7 in order, held stable during stalls, rlast on beat 8, rid echoed.
- **Partial strobe:** write 0x8000_0008 with strb 0x0F and data 0xFFFF_FFFF_FFFF_FFFF over prior data 0 → readback 0x0000_0000_FFFF_FFFF.
- **Error responses:** address 0x1000_0000 → DECERR with memory untouched. WRAP burst len=3 → 4 beats with SLVERR. W burst with wlast on beat 2 of len=3 → SLVERR after 4 beats.
- **Concurrency:** an AW and an AR burst issued in the same cycle to disjoint regions → both complete with correct data. A read and write of the same word in the same cycle → read returns the old value.
- **Reset mid-burst:** assert reset_n=0 during beat 3 of a read burst → all outputs 0 asynchronously. After release, awready and arready are 1 and the earlier written data is still readable.

Source files
------------

// File: rtl/axi_mem_responder_if.sv
// AXI4 64-bit bus bundle between a master port and the BRAM responder.
// Signal names follow the AXI channel names; the instance name carries the port prefix.
interface axi_mem_responder_if;
   logic        awvalid;
   logic        awready;
   logic [31:0] awaddr;
   logic [5:0]  awid;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;

   logic        wvalid;
   logic        wready;
   logic [63:0] wdata;
   logic [7:0]  wstrb;
   logic        wlast;

   logic        bvalid;
   logic        bready;
   logic [5:0]  bid;
   logic [1:0]  bresp;

   logic        arvalid;
   logic        arready;
   logic [31:0] araddr;
   logic [5:0]  arid;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;

   logic        rvalid;
   logic        rready;
   logic [63:0] rdata;
   logic [5:0]  rid;
   logic [1:0]  rresp;
   logic        rlast;

   modport master (
      output awvalid, awaddr, awid, awlen, awsize, awburst,
      output wvalid, wdata, wstrb, wlast,
      output bready,
      output arvalid, araddr, arid, arlen, arsize, arburst,
      output rready,
      input  awready, wready, bvalid, bid, bresp,
      input  arready, rvalid, rdata, rid, rresp, rlast
   );

   modport slave (
      input  awvalid, awaddr, awid, awlen, awsize, awburst,
      input  wvalid, wdata, wstrb, wlast,
      input  bready,
      input  arvalid, araddr, arid, arlen, arsize, arburst,
      input  rready,
      output awready, wready, bvalid, bid, bresp,
      output arready, rvalid, rdata, rid, rresp, rlast
   );
endinterface

// File: rtl/axi_mem_responder.sv
// AXI4 64-bit slave terminated by a dual-port on-chip BRAM.
// Independent read and write FSMs, one outstanding burst per channel.
module axi_mem_responder #(
   parameter int unsigned MEM_WORDS_LOG2 = 12,
   parameter logic [3:0]  BASE_HI        = 4'h8
) (
   input logic                clock,
   input logic                reset_n,
   axi_mem_responder_if.slave s_axi
);
   localparam int unsigned IW = MEM_WORDS_LOG2;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_FILL, R_DATA} r_state_t;

   function automatic logic in_range(input logic [31:0] a);
      logic [27:0] hi;
      hi = a[27:0] >> (IW + 3);
      return (a[31:28] == BASE_HI) && (hi == '0);
   endfunction

   function automatic logic odd_burst(
      input logic [2:0] sz,
      input logic [1:0] bu
   );
      return bu[1] || (sz > 3'd3);
   endfunction

   function automatic logic [IW-1:0] word_idx(input logic [31:0] a);
      return a[IW+2:3];
   endfunction

   function automatic logic [1:0] beat_resp(
      input logic [31:0] a,
      input logic        bad
   );
      if (bad) return SLVERR;
      if (!in_range(a)) return DECERR;
      return OKAY;
   endfunction

   logic [63:0] mem [0:(1<<IW)-1];
   logic [63:0] mem_q;

   w_state_t    w_state;
   logic        awready_q;
   logic        wready_q;
   logic        bvalid_q;
   logic [5:0]  bid_q;
   logic [1:0]  bresp_q;
   logic [31:0] w_addr;
   logic [7:0]  w_len;
   logic [2:0]  w_size;
   logic        w_incr;
   logic        w_bad;
   logic [8:0]  w_beat;
   logic        w_slverr;
   logic        w_decerr;

   r_state_t    r_state;
   logic        arready_q;
   logic        rvalid_q;
   logic        rlast_q;
   logic [5:0]  rid_q;
   logic [1:0]  rresp_q;
   logic [31:0] r_addr;
   logic [7:0]  r_len;
   logic [2:0]  r_size;
   logic        r_incr;
   logic        r_bad;
   logic [8:0]  r_beat;

   logic        aw_hs;
   logic        w_hs;
   logic        w_last;
   logic        w_ok;
   logic        w_we;
   logic        w_slv_nx;
   logic        w_dec_nx;
   logic [31:0] w_addr_nx;

   logic        ar_hs;
   logic        r_hs;
   logic        r_last;
   logic [31:0] r_addr_nx;
   logic        rd_en;
   logic [IW-1:0] rd_idx;

   assign aw_hs     = awready_q & s_axi.awvalid;
   assign w_hs      = wready_q & s_axi.wvalid;
   assign w_last    = w_beat == {1'b0, w_len};
   assign w_ok      = in_range(w_addr);
   assign w_we      = w_hs & w_ok & ~w_bad;
   assign w_slv_nx  = w_slverr | (s_axi.wlast != w_last);
   assign w_dec_nx  = w_decerr | ~w_ok;
   assign w_addr_nx = w_incr ? w_addr + (32'd1 << w_size) : w_addr;

   assign ar_hs     = arready_q & s_axi.arvalid;
   assign r_hs      = rvalid_q & s_axi.rready;
   assign r_last    = r_beat == {1'b0, r_len};
   assign r_addr_nx = r_incr ? r_addr + (32'd1 << r_size) : r_addr;
   assign rd_en     = ar_hs | (r_hs & ~r_last);
   assign rd_idx    = ar_hs ? word_idx(s_axi.araddr)
                            : word_idx(r_addr_nx);

   assign s_axi.awready = awready_q;
   assign s_axi.wready  = wready_q;
   assign s_axi.bvalid  = bvalid_q;
   assign s_axi.bid     = bid_q;
   assign s_axi.bresp   = bresp_q;
   assign s_axi.arready = arready_q;
   assign s_axi.rvalid  = rvalid_q;
   assign s_axi.rlast   = rlast_q;
   assign s_axi.rid     = rid_q;
   assign s_axi.rresp   = rresp_q;
   // mem_q only reloads on a handshake, so stalled beats stay stable
   assign s_axi.rdata   = (rvalid_q && rresp_q == OKAY) ? mem_q : '0;

   always_ff @(posedge clock) begin
      if (w_we) begin
         for (int b = 0; b < 8; b++) begin
            if (s_axi.wstrb[b]) begin
               mem[word_idx(w_addr)][8*b +: 8] <= s_axi.wdata[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (rd_en) mem_q <= mem[rd_idx];
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         w_state   <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bid_q     <= '0;
         bresp_q   <= OKAY;
         w_addr    <= '0;
         w_len     <= '0;
         w_size    <= '0;
         w_incr    <= 1'b0;
         w_bad     <= 1'b0;
         w_beat    <= '0;
         w_slverr  <= 1'b0;
         w_decerr  <= 1'b0;
      end else begin
         unique case (w_state)
            W_IDLE: begin
               awready_q <= 1'b1;
               if (aw_hs) begin
                  awready_q <= 1'b0;
                  wready_q  <= 1'b1;
                  bid_q     <= s_axi.awid;
                  w_addr    <= s_axi.awaddr;
                  w_len     <= s_axi.awlen;
                  w_size    <= s_axi.awsize;
                  w_incr    <= s_axi.awburst == 2'b01;
                  w_bad     <= odd_burst(s_axi.awsize, s_axi.awburst);
                  w_slverr  <= odd_burst(s_axi.awsize, s_axi.awburst);
                  w_decerr  <= 1'b0;
                  w_beat    <= '0;
                  w_state   <= W_DATA;
               end
            end
            W_DATA: begin
               if (w_hs) begin
                  w_slverr <= w_slv_nx;
                  w_decerr <= w_dec_nx;
                  w_beat   <= w_beat + 9'd1;
                  w_addr   <= w_addr_nx;
                  if (w_last) begin
                     wready_q <= 1'b0;
                     bvalid_q <= 1'b1;
                     bresp_q  <= w_slv_nx ? SLVERR :
                                 w_dec_nx ? DECERR : OKAY;
                     w_state  <= W_RESP;
                  end
               end
            end
            W_RESP: begin
               if (s_axi.bready) begin
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  w_state   <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rid_q     <= '0;
         rresp_q   <= OKAY;
         r_addr    <= '0;
         r_len     <= '0;
         r_size    <= '0;
         r_incr    <= 1'b0;
         r_bad     <= 1'b0;
         r_beat    <= '0;
      end else begin
         unique case (r_state)
            R_IDLE: begin
               arready_q <= 1'b1;
               if (ar_hs) begin
                  arready_q <= 1'b0;
                  rid_q     <= s_axi.arid;
                  r_addr    <= s_axi.araddr;
                  r_len     <= s_axi.arlen;
                  r_size    <= s_axi.arsize;
                  r_incr    <= s_axi.arburst == 2'b01;
                  r_bad     <= odd_burst(s_axi.arsize, s_axi.arburst);
                  r_beat    <= '0;
                  r_state   <= R_FILL;
               end
            end
            R_FILL: begin
               rvalid_q <= 1'b1;
               rlast_q  <= r_len == 8'd0;
               rresp_q  <= beat_resp(r_addr, r_bad);
               r_state  <= R_DATA;
            end
            R_DATA: begin
               if (r_hs) begin
                  if (r_last) begin
                     rvalid_q  <= 1'b0;
                     rlast_q   <= 1'b0;
                     arready_q <= 1'b1;
                     r_state   <= R_IDLE;
                  end else begin
                     r_beat  <= r_beat + 9'd1;
                     r_addr  <= r_addr_nx;
                     rlast_q <= (r_beat + 9'd1) == {1'b0, r_len};
                     rresp_q <= beat_resp(r_addr_nx, r_bad);
                  end
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed plus randomized bench for axi_mem_responder.
// Expected responses come from a word-array model and burst address arithmetic.
module tb_axi_mem_responder;
   logic clock = 1'b0;
   logic reset_n;
   int   total = 0;
   int   bad = 0;

   axi_mem_responder_if s_axi ();

   axi_mem_responder #(
      .MEM_WORDS_LOG2(12),
      .BASE_HI       (4'h8)
   ) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .s_axi  (s_axi)
   );

   always #5 clock = ~clock;

   logic [63:0] mdl [0:4095];
   logic [63:0] wd  [0:255];
   logic [7:0]  ws  [0:255];

   task automatic chk(
      input string       tag,
      input logic [63:0] got,
      input logic [63:0] exp
   );
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic in_rng(input logic [31:0] a);
      return a[31:28] == 4'h8 && a[27:15] == 13'd0;
   endfunction

   function automatic logic odd_burst(
      input logic [2:0] sz,
      input logic [1:0] bu
   );
      return bu > 2'd1 || sz > 3'd3;
   endfunction

   function automatic logic [31:0] baddr(
      input logic [31:0] a,
      input logic [2:0]  sz,
      input logic [1:0]  bu,
      input int          i
   );
      return (bu == 2'd0) ? a : a + 32'(i) * (32'd1 << sz);
   endfunction

   task automatic chk_zero(input string tag);
      chk({tag, ".awready"}, 64'(s_axi.awready), 0);
      chk({tag, ".wready"},  64'(s_axi.wready),  0);
      chk({tag, ".bvalid"},  64'(s_axi.bvalid),  0);
      chk({tag, ".bid"},     64'(s_axi.bid),     0);
      chk({tag, ".bresp"},   64'(s_axi.bresp),   0);
      chk({tag, ".arready"}, 64'(s_axi.arready), 0);
      chk({tag, ".rvalid"},  64'(s_axi.rvalid),  0);
      chk({tag, ".rdata"},   s_axi.rdata,        0);
      chk({tag, ".rid"},     64'(s_axi.rid),     0);
      chk({tag, ".rresp"},   64'(s_axi.rresp),   0);
      chk({tag, ".rlast"},   64'(s_axi.rlast),   0);
   endtask

   // Write burst from wd/ws; wlast is raised only on beat wl.
   task automatic w_txn(
      input logic [31:0] a,
      input logic [5:0]  id,
      input int          len,
      input logic [2:0]  sz,
      input logic [1:0]  bu,
      input int          wl
   );
      int          n;
      logic        ob;
      logic        oor;
      logic [31:0] ba;
      logic [1:0]  er;
      @(negedge clock);
      s_axi.awvalid = 1'b1;
      s_axi.awaddr  = a;
      s_axi.awid    = id;
      s_axi.awlen   = 8'(len);
      s_axi.awsize  = sz;
      s_axi.awburst = bu;
      n = 0;
      while (s_axi.awready !== 1'b1 && n < 50) begin
         @(negedge clock);
         n++;
      end
      chk("aw_accept", 64'(n < 50), 1);
      @(negedge clock);
      s_axi.awvalid = 1'b0;
      for (int i = 0; i <= len; i++) begin
         s_axi.wvalid = 1'b1;
         s_axi.wdata  = wd[i];
         s_axi.wstrb  = ws[i];
         s_axi.wlast  = (i == wl);
         n = 0;
         while (s_axi.wready !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
         end
         if (n >= 50) chk("w_accept", 64'(n), 0);
         @(negedge clock);
      end
      s_axi.wvalid = 1'b0;
      s_axi.wlast  = 1'b0;
      ob  = odd_burst(sz, bu);
      oor = 1'b0;
      for (int i = 0; i <= len; i++) begin
         ba = baddr(a, sz, bu, i);
         if (!in_rng(ba)) oor = 1'b1;
         else if (!ob) begin
            for (int b = 0; b < 8; b++) begin
               if (ws[i][b]) mdl[ba[14:3]][8*b +: 8] = wd[i][8*b +: 8];
            end
         end
      end
      er = (ob || wl != len) ? 2'b10 : oor ? 2'b11 : 2'b00;
      chk("b_valid", 64'(s_axi.bvalid), 1);
      chk("b_resp",  64'(s_axi.bresp), 64'(er));
      chk("b_id",    64'(s_axi.bid), 64'(id));
      @(negedge clock);
      chk("b_hold_resp", 64'(s_axi.bresp), 64'(er));
      chk("b_hold_id",   64'(s_axi.bid), 64'(id));
      s_axi.bready = 1'b1;
      @(negedge clock);
      s_axi.bready = 1'b0;
      chk("b_done",   64'(s_axi.bvalid), 0);
      chk("aw_again", 64'(s_axi.awready), 1);
   endtask

   // Read burst; mode 0 rready high, 1 toggling, 2 random.
   task automatic r_txn(
      input logic [31:0] a,
      input logic [5:0]  id,
      input int          len,
      input logic [2:0]  sz,
      input logic [1:0]  bu,
      input int          mode
   );
      logic [63:0] ed [0:255];
      logic [1:0]  er [0:255];
      logic [31:0] ba;
      logic        ob;
      int          n;
      int          beat;
      ob = odd_burst(sz, bu);
      for (int i = 0; i <= len; i++) begin
         ba = baddr(a, sz, bu, i);
         if (ob) begin
            ed[i] = '0;
            er[i] = 2'b10;
         end else if (!in_rng(ba)) begin
            ed[i] = '0;
            er[i] = 2'b11;
         end else begin
            ed[i] = mdl[ba[14:3]];
            er[i] = 2'b00;
         end
      end
      @(negedge clock);
      s_axi.arvalid = 1'b1;
      s_axi.araddr  = a;
      s_axi.arid    = id;
      s_axi.arlen   = 8'(len);
      s_axi.arsize  = sz;
      s_axi.arburst = bu;
      n = 0;
      while (s_axi.arready !== 1'b1 && n < 50) begin
         @(negedge clock);
         n++;
      end
      chk("ar_accept", 64'(n < 50), 1);
      @(negedge clock);
      s_axi.arvalid = 1'b0;
      chk("r_fill_gap", 64'(s_axi.rvalid), 0);
      @(negedge clock);
      chk("r_first", 64'(s_axi.rvalid), 1);
      beat = 0;
      n = 0;
      while (beat <= len && n < 4 * len + 40) begin
         if (mode == 0) s_axi.rready = 1'b1;
         else if (mode == 1) s_axi.rready = (n % 2) == 1;
         else s_axi.rready = 1'($urandom_range(0, 1));
         if (s_axi.rvalid === 1'b1) begin
            chk("r_data", s_axi.rdata, ed[beat]);
            chk("r_resp", 64'(s_axi.rresp), 64'(er[beat]));
            chk("r_last", 64'(s_axi.rlast), 64'(beat == len));
            chk("r_id",   64'(s_axi.rid), 64'(id));
            if (s_axi.rready) beat++;
         end
         @(negedge clock);
         n++;
      end
      s_axi.rready = 1'b0;
      chk("r_beats", 64'(beat), 64'(len + 1));
      if (mode == 0) chk("r_cycles", 64'(n), 64'(len + 1));
      chk("r_end_valid", 64'(s_axi.rvalid), 0);
      chk("ar_again",    64'(s_axi.arready), 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] a;
      logic [63:0] v0;
      logic [63:0] v1;
      logic [2:0]  sz;
      logic [1:0]  bu;
      logic [5:0]  id;
      int          len;
      int          n;

      reset_n = 1'b0;
      s_axi.awvalid = 0; s_axi.awaddr = 0; s_axi.awid = 0;
      s_axi.awlen = 0; s_axi.awsize = 0; s_axi.awburst = 0;
      s_axi.wvalid = 0; s_axi.wdata = 0; s_axi.wstrb = 0;
      s_axi.wlast = 0; s_axi.bready = 0;
      s_axi.arvalid = 0; s_axi.araddr = 0; s_axi.arid = 0;
      s_axi.arlen = 0; s_axi.arsize = 0; s_axi.arburst = 0;
      s_axi.rready = 0;

      repeat (3) @(negedge clock);
      chk_zero("reset");
      reset_n = 1'b1;
      #1;
      chk("aw_pre", 64'(s_axi.awready), 0);
      @(negedge clock);
      chk("aw_post", 64'(s_axi.awready), 1);
      chk("ar_post", 64'(s_axi.arready), 1);
      chk("w_post",  64'(s_axi.wready), 0);

      // known contents for the low 2 KiB; 256 beats exercises len=255
      for (int i = 0; i < 256; i++) begin
         wd[i] = {$urandom, $urandom};
         ws[i] = 8'hFF;
      end
      w_txn(32'h8000_0000, 6'd1, 255, 3'd3, 2'b01, 255);
      r_txn(32'h8000_0000, 6'd2, 255, 3'd3, 2'b01, 0);

      wd[0] = 64'h0123_4567_89AB_CDEF; ws[0] = 8'hFF;
      w_txn(32'h8000_0040, 6'd5, 0, 3'd3, 2'b01, 0);
      r_txn(32'h8000_0040, 6'd6, 0, 3'd3, 2'b01, 0);

      for (int i = 0; i < 8; i++) begin
         wd[i] = 64'(i);
         ws[i] = 8'hFF;
      end
      w_txn(32'h8000_0100, 6'h2A, 7, 3'd3, 2'b01, 7);
      r_txn(32'h8000_0100, 6'h2A, 7, 3'd3, 2'b01, 1);

      wd[0] = '0; ws[0] = 8'hFF;
      w_txn(32'h8000_0008, 6'd3, 0, 3'd3, 2'b01, 0);
      wd[0] = '1; ws[0] = 8'h0F;
      w_txn(32'h8000_0008, 6'd3, 0, 3'd3, 2'b01, 0);
      r_txn(32'h8000_0008, 6'd3, 0, 3'd3, 2'b01, 0);

      wd[0] = 64'hDEAD_BEEF_0000_1111; ws[0] = 8'hFF;
      w_txn(32'h1000_0000, 6'd7, 0, 3'd3, 2'b01, 0);
      r_txn(32'h8000_0000, 6'd7, 0, 3'd3, 2'b01, 0);
      r_txn(32'h1000_0000, 6'd8, 1, 3'd3, 2'b01, 0);

      for (int i = 0; i < 4; i++) begin
         wd[i] = {$urandom, $urandom};
         ws[i] = 8'hFF;
      end
      w_txn(32'h8000_0100, 6'd9, 3, 3'd3, 2'b10, 3);
      r_txn(32'h8000_0100, 6'd9, 3, 3'd3, 2'b10, 0);
      r_txn(32'h8000_0100, 6'd9, 3, 3'd3, 2'b01, 0);
      r_txn(32'h8000_0100, 6'd4, 1, 3'd4, 2'b01, 0);
      w_txn(32'h8000_0180, 6'd10, 3, 3'd3, 2'b01, 1);
      r_txn(32'h8000_0180, 6'd10, 3, 3'd3, 2'b01, 2);

      // INCR past the top of memory: last two beats decode-error
      w_txn(32'h8000_7FF0, 6'd11, 3, 3'd3, 2'b01, 3);
      r_txn(32'h8000_7FF0, 6'd11, 3, 3'd3, 2'b01, 0);

      for (int i = 0; i < 4; i++) begin
         wd[i] = {$urandom, $urandom};
         ws[i] = 8'hFF;
      end
      fork
         w_txn(32'h8000_0200, 6'd12, 3, 3'd3, 2'b01, 3);
         r_txn(32'h8000_0300, 6'd13, 3, 3'd3, 2'b01, 2);
      join
      r_txn(32'h8000_0200, 6'd14, 3, 3'd3, 2'b01, 0);

      // same-word read and write on one edge: read sees old data
      v0 = mdl[9];
      v1 = ~v0;
      @(negedge clock);
      s_axi.awvalid = 1'b1; s_axi.awaddr = 32'h8000_0048;
      s_axi.awid = 6'd15; s_axi.awlen = 0;
      s_axi.awsize = 3'd3; s_axi.awburst = 2'b01;
      n = 0;
      while (s_axi.awready !== 1'b1 && n < 50) begin
         @(negedge clock);
         n++;
      end
      @(negedge clock);
      s_axi.awvalid = 1'b0;
      chk("col_wready",  64'(s_axi.wready), 1);
      chk("col_arready", 64'(s_axi.arready), 1);
      s_axi.arvalid = 1'b1; s_axi.araddr = 32'h8000_0048;
      s_axi.arid = 6'd16; s_axi.arlen = 0;
      s_axi.arsize = 3'd3; s_axi.arburst = 2'b01;
      s_axi.wvalid = 1'b1; s_axi.wdata = v1;
      s_axi.wstrb = 8'hFF; s_axi.wlast = 1'b1;
      @(negedge clock);
      s_axi.arvalid = 1'b0; s_axi.wvalid = 1'b0; s_axi.wlast = 1'b0;
      chk("col_bvalid", 64'(s_axi.bvalid), 1);
      chk("col_fill",   64'(s_axi.rvalid), 0);
      @(negedge clock);
      chk("col_rvalid", 64'(s_axi.rvalid), 1);
      chk("col_old",    s_axi.rdata, v0);
      s_axi.rready = 1'b1;
      s_axi.bready = 1'b1;
      @(negedge clock);
      s_axi.rready = 1'b0;
      s_axi.bready = 1'b0;
      mdl[9] = v1;
      r_txn(32'h8000_0048, 6'd17, 0, 3'd3, 2'b01, 0);

      for (int t = 0; t < 16; t++) begin
         sz  = 3'($urandom_range(0, 3));
         bu  = 2'($urandom_range(0, 1));
         len = int'($urandom_range(0, 15));
         id  = 6'($urandom_range(0, 63));
         a   = 32'h8000_0000 + $urandom_range(0, 32'h700);
         for (int i = 0; i <= len; i++) begin
            wd[i] = {$urandom, $urandom};
            ws[i] = 8'($urandom_range(0, 255));
         end
         w_txn(a, id, len, sz, bu, len);
         r_txn(a, id ^ 6'd1, len, sz, bu, 2);
      end

      // reset during the third beat of a read burst
      @(negedge clock);
      s_axi.arvalid = 1'b1; s_axi.araddr = 32'h8000_0100;
      s_axi.arid = 6'd3; s_axi.arlen = 8'd7;
      s_axi.arsize = 3'd3; s_axi.arburst = 2'b01;
      n = 0;
      while (s_axi.arready !== 1'b1 && n < 50) begin
         @(negedge clock);
         n++;
      end
      @(negedge clock);
      s_axi.arvalid = 1'b0;
      s_axi.rready = 1'b1;
      repeat (3) @(negedge clock);
      chk("rst_beat3", s_axi.rdata, mdl[34]);
      #2;
      reset_n = 1'b0;
      #1;
      chk_zero("midrst");
      s_axi.rready = 1'b0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      #1;
      chk("rst_aw_pre", 64'(s_axi.awready), 0);
      @(negedge clock);
      chk("rst_aw", 64'(s_axi.awready), 1);
      chk("rst_ar", 64'(s_axi.arready), 1);
      r_txn(32'h8000_0040, 6'd20, 0, 3'd3, 2'b01, 0);
      r_txn(32'h8000_0100, 6'd21, 7, 3'd3, 2'b01, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
